// File: rtl/btb_pkg.sv
// btb_pkg: shared widths, entry-field offsets and types for the BTB lookup slice.
`default_nettype none

package btb_pkg;

  localparam int PC_W    = 11;
  localparam int TAG_W   = 5;
  localparam int IDX_W   = 6;
  localparam int ENTRY_W = 19;

  localparam int TARGET_LSB = 0;
  localparam int TAG_LSB    = 11;
  localparam int VALID_BIT  = 16;
  localparam int CNT_LSB    = 17;

  localparam logic [1:0] COUNTER_MISS = 2'b01;

  typedef struct packed {
    logic [1:0]       counter;
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  typedef struct packed {
    logic             valid;
    logic [1:0]       prev_counter;
    logic             prev_valid;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic             pred_taken;
  } btb_meta_t;

  function automatic btb_entry_t unpack_entry(input logic [ENTRY_W-1:0] d);
    btb_entry_t e;
    e.target  = d[TARGET_LSB +: PC_W];
    e.tag     = d[TAG_LSB +: TAG_W];
    e.valid   = d[VALID_BIT];
    e.counter = d[CNT_LSB +: 2];
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_lookup_table_if.sv
// btb_lookup_table_if: fetch, prediction, execute-metadata and write bundle of the BTB.
`default_nettype none

interface btb_lookup_table_if;
  import btb_pkg::*;

  logic [PC_W-1:0]  fetch_pc;
  logic             fetch_valid;
  logic             stall;
  logic             flush;
  logic             pred_valid;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             ex_meta_valid;
  logic [1:0]       ex_prev_counter;
  logic             ex_prev_valid;
  logic [TAG_W-1:0] ex_tag;
  logic [IDX_W-1:0] ex_index;
  logic             ex_pred_taken;
  logic             wr_enable;
  logic [IDX_W-1:0] wr_index;
  logic [31:0]      wr_data;

  modport master (
    output fetch_pc, fetch_valid, stall, flush, wr_enable, wr_index, wr_data,
    input  pred_valid, pred_taken, pred_target, ex_meta_valid, ex_prev_counter,
           ex_prev_valid, ex_tag, ex_index, ex_pred_taken
  );

  modport slave (
    input  fetch_pc, fetch_valid, stall, flush, wr_enable, wr_index, wr_data,
    output pred_valid, pred_taken, pred_target, ex_meta_valid, ex_prev_counter,
           ex_prev_valid, ex_tag, ex_index, ex_pred_taken
  );

endinterface

`default_nettype wire

// File: rtl/btb_meta_pipe.sv
// btb_meta_pipe: one lookup-metadata stage; flush kills valid, stall holds everything.
`default_nettype none

module btb_meta_pipe
  import btb_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      stall,
  input  logic      flush,
  input  btb_meta_t meta_in,
  output btb_meta_t meta_out
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_out <= '0;
    end else if (flush) begin
      meta_out.valid <= 1'b0;
    end else if (!stall) begin
      meta_out <= meta_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/btb_lookup_table.sv
// btb_lookup_table: 64-entry BTB array, registered lookup and metadata pipe to execute.
// Define BTB_WR_BYPASS_EN to forward a same-cycle write to a lookup of the same index. Rev 1.0
`default_nettype none

module btb_lookup_table
  import btb_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int IDX_W      = 6
) (
  input logic               clk,
  input logic               reset_n,
  btb_lookup_table_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_W;

  btb_entry_t       mem [ENTRIES];
  btb_entry_t       wr_entry;
  btb_entry_t       rd_entry;
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             hit;
  btb_meta_t        lookup_meta;
  btb_meta_t        pred_meta;
  logic [PC_W-1:0]  pred_target;
  btb_meta_t        stage_meta [PIPE_DEPTH+1];
  logic             unused_wr_hi;

  assign wr_entry     = unpack_entry(bus.wr_data[ENTRY_W-1:0]);
  assign unused_wr_hi = ^bus.wr_data[31:ENTRY_W];
  assign fetch_idx    = bus.fetch_pc[IDX_W-1:0];
  assign fetch_tag    = bus.fetch_pc[PC_W-1:IDX_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.wr_enable) begin
      mem[bus.wr_index] <= wr_entry;
    end
  end

  always_comb begin
    rd_entry = mem[fetch_idx];
`ifdef BTB_WR_BYPASS_EN
    if (bus.wr_enable && (bus.wr_index == fetch_idx)) begin
      rd_entry = wr_entry;
    end
`endif
  end

  assign hit = rd_entry.valid && (rd_entry.tag == fetch_tag);

  // A miss reports the weakly-not-taken default, never the foreign entry's counter.
  always_comb begin
    lookup_meta              = '0;
    lookup_meta.valid        = 1'b1;
    lookup_meta.prev_counter = hit ? rd_entry.counter : COUNTER_MISS;
    lookup_meta.prev_valid   = hit;
    lookup_meta.tag          = fetch_tag;
    lookup_meta.index        = fetch_idx;
    lookup_meta.pred_taken   = hit && rd_entry.counter[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_meta   <= '0;
      pred_target <= '0;
    end else if (bus.flush) begin
      pred_meta.valid <= 1'b0;
    end else if (!bus.stall) begin
      pred_meta.valid <= bus.fetch_valid;
      if (bus.fetch_valid) begin
        pred_meta   <= lookup_meta;
        pred_target <= hit ? rd_entry.target : '0;
      end
    end
  end

  assign stage_meta[0] = pred_meta;

  generate
    for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_meta_pipe
      btb_meta_pipe u_stage (
        .clk      (clk),
        .reset_n  (reset_n),
        .stall    (bus.stall),
        .flush    (bus.flush),
        .meta_in  (stage_meta[s]),
        .meta_out (stage_meta[s+1])
      );
    end
  endgenerate

  assign bus.pred_valid      = pred_meta.valid;
  assign bus.pred_taken      = pred_meta.pred_taken;
  assign bus.pred_target     = pred_target;
  assign bus.ex_meta_valid   = stage_meta[PIPE_DEPTH].valid;
  assign bus.ex_prev_counter = stage_meta[PIPE_DEPTH].prev_counter;
  assign bus.ex_prev_valid   = stage_meta[PIPE_DEPTH].prev_valid;
  assign bus.ex_tag          = stage_meta[PIPE_DEPTH].tag;
  assign bus.ex_index        = stage_meta[PIPE_DEPTH].index;
  assign bus.ex_pred_taken   = stage_meta[PIPE_DEPTH].pred_taken;

endmodule

`default_nettype wire

// File: doc/btb_lookup_table.md
# btb_lookup_table

Branch target buffer storage and lookup stage. Holds 64 BHT/BTB entries, performs a registered lookup on the fetch PC to produce a taken/target prediction, and carries the lookup metadata (previous counter, valid, tag, index) down to execute. At execute it feeds the write-data builder. It also accepts that builder's `wr_data`/`wr_enable` to update the array.

## Interface
Parameters:
- `PIPE_DEPTH`, default 2: register stages between the prediction output and the `ex_*` outputs (1..4).
- `IDX_W`, default 6: index width; entry count is 2^IDX_W.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `fetch_pc` in 11: PC being fetched. Index = `fetch_pc[5:0]`, tag = `fetch_pc[10:6]`.
- `fetch_valid` in 1: a lookup is requested this cycle.
- `stall` in 1: holds the prediction register and metadata pipeline.
- `flush` in 1: kills all in-flight lookups.
- `pred_valid` out 1: `pred_*` outputs are meaningful.
- `pred_taken` out 1: hit and counter MSB = 1.
- `pred_target` out 11: stored target when there is a hit, else 0.
- `ex_meta_valid` out 1: `ex_*` outputs are meaningful.
- `ex_prev_counter` out 2: counter captured at lookup.
- `ex_prev_valid` out 1: hit flag captured at lookup.
- `ex_tag` out 5: tag of the looked-up PC.
- `ex_index` out 6: index of the looked-up PC.
- `ex_pred_taken` out 1: prediction made for this instruction.
- `wr_enable` in 1: write strobe from the data builder.
- `wr_index` in 6: entry to write.
- `wr_data` in 32: entry image. Fields: [10:0] target, [15:11] tag, [16] valid, [18:17] counter; [31:19] ignored, stored as 0.

## Operation
- Array: 64 × 19 bits of flops. Reset clears every entry to 0, so all entries are invalid.
- Hit = entry.valid AND entry.tag == `fetch_pc[10:6]`.
- Lookup is captured into the prediction register when `fetch_valid && !stall`:
  - `pred_taken` = hit & counter[1].
  - `pred_target` = hit ? target : 0.
- Metadata on a hit: `prev_counter` = entry counter, `prev_valid` = 1.
- Metadata on a miss: `prev_counter` = 2'b01 (weakly not-taken), `prev_valid` = 0. A foreign tag's counter is never forwarded.
- Metadata pipeline: PIPE_DEPTH stages behind the prediction register. It shifts on every non-stall cycle; a bubble (valid = 0) enters when `fetch_valid` = 0.
- Write: when `wr_enable` is high, `entry[wr_index]` <= `wr_data[18:0]` at the edge. Writes proceed regardless of `stall` or `flush`.
- Flush: the next edge clears `pred_valid` and every pipeline valid bit. Data fields may keep stale values. Flush has priority over stall.
- Stall without flush: all prediction and pipeline registers hold, and outputs are unchanged.
- Metadata is a snapshot taken at lookup. A write to the same index between lookup and execute is not reflected; the builder acts on the snapshot by design.

## Timing
- Reset values: all `pred_*` and `ex_*` outputs are 0.
- Lookup latency: `fetch_pc` sampled at edge T appears on `pred_*` after T.
- Execute latency: with no stalls, that lookup appears on `ex_*` PIPE_DEPTH edges later.
- Each stall cycle adds one cycle of latency.
- Write latency: a write at edge T is visible to lookups sampled at edge T+1.
- Same-cycle read and write of the same index: see Configuration.
- Reset asserted mid-operation clears the array and all pipeline state immediately. The first lookup is accepted at the first edge after release.

## Configuration
- `BTB_WR_BYPASS_EN` defined: on a same-cycle lookup and write to the same index, the lookup uses `wr_data[18:0]` (write-to-read forwarding).
- `BTB_WR_BYPASS_EN` undefined: that lookup uses the old array contents.

## Structure
- Shared package `btb_pkg`:
  - PC_W = 11, TAG_W = 5, IDX_W = 6, ENTRY_W = 19.
  - Field offset constants TARGET_LSB = 0, TAG_LSB = 11, VALID_BIT = 16, CNT_LSB = 17.
  - COUNTER_MISS = 2'b01.
  - Packed entry typedef and metadata struct typedef.
- One sub-module, `btb_meta_pipe`: a single metadata stage with valid/stall/flush behaviour, instantiated PIPE_DEPTH times via generate.

## Test plan
- Reset, then lookup `fetch_pc` = 11'h123 → after 1 cycle `pred_valid`=1, `pred_taken`=0, `pred_target`=0. After PIPE_DEPTH more cycles: `ex_prev_valid`=0, `ex_prev_counter`=01, `ex_tag`=5'h04, `ex_index`=6'h23.
- Write index 6'h23 with tag 5'h04, valid 1, counter 11, target 11'h0F0, then look up 11'h123 → `pred_taken`=1, `pred_target`=11'h0F0, `ex_prev_counter`=11.
- Same index, tag mismatch (`fetch_pc` = 11'h163) → `pred_taken`=0, `ex_prev_valid`=0, `ex_prev_counter`=01.
- Lookup followed by 3 stall cycles, then flush → `pred_*` held for 3 cycles, then `pred_valid`=0 and `ex_meta_valid` never asserts for that lookup.
- Same-cycle write and lookup of index 6'h05:
  - With the macro defined: the prediction reflects the new data.
  - Without it: the prediction reflects the old data.
- Reset asserted mid-stream with 2 lookups in flight → all outputs 0 immediately. A lookup of a previously written PC after release misses.
